// File: rtl/v_pkg.sv
// Shared types, opcodes and FSM state encoding for the message decoder.
package v_pkg;

  typedef logic [7:0]  id_t;
  typedef logic [15:0] key_t;
  typedef logic [15:0] size_t;
  typedef logic [3:0]  level_t;

  typedef enum logic [1:0] {
    CMD_ADD     = 2'd0,
    CMD_DEL     = 2'd1,
    CMD_REPLACE = 2'd2
  } cmd_t;

  localparam logic [7:0] OP_ADD     = 8'h01;
  localparam logic [7:0] OP_DEL     = 8'h02;
  localparam logic [7:0] OP_REPLACE = 8'h03;
  localparam logic [7:0] OP_QUERY   = 8'h10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  function automatic logic is_upd_op(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_DEL) || (op == OP_REPLACE);
  endfunction

  function automatic cmd_t op_to_cmd(input logic [7:0] op);
    case (op)
      OP_DEL:     return CMD_DEL;
      OP_REPLACE: return CMD_REPLACE;
      default:    return CMD_ADD;
    endcase
  endfunction

endpackage

// File: rtl/v_msg_dec.sv
// Message decoder: turns beat streams into registered list-update and list-query pulses,
// counting dropped messages in a saturating counter.
//   state   | meaning
//   IDLE    | waiting for a sop beat
//   BODY    | update header captured, waiting for the size beat
//   DROP    | discarding non-sop beats of a bad message
module v_msg_dec
  import v_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_msg_vld,
  input  logic                 i_msg_sop,
  input  logic [31:0]          i_msg_data,
  output logic                 o_msg_rdy,
  output logic                 o_upd_vld,
  output id_t                  o_upd_prod_id,
  output cmd_t                 o_upd_cmd,
  output key_t                 o_upd_key,
  output size_t                o_upd_size,
  output logic                 o_lut_vld,
  output id_t                  o_lut_prod_id,
  output level_t               o_lut_level,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  state_t state_q, state_d;
  logic rdy_pre_q, rdy_q;
  id_t  cap_prod_q, cap_prod_d;
  cmd_t cap_cmd_q, cap_cmd_d;
  key_t cap_key_q, cap_key_d;
  logic upd_vld_q, upd_vld_d;
  id_t upd_prod_q, upd_prod_d;
  cmd_t upd_cmd_q, upd_cmd_d;
  key_t upd_key_q, upd_key_d;
  size_t upd_size_q, upd_size_d;
  logic lut_vld_q, lut_vld_d;
  id_t lut_prod_q, lut_prod_d;
  level_t lut_level_q, lut_level_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic err_inc;
  logic accept;
  logic [7:0] op;

  assign accept = i_msg_vld & rdy_q;
  assign op     = i_msg_data[31:24];

  always_comb begin
    state_d     = state_q;
    cap_prod_d  = cap_prod_q;
    cap_cmd_d   = cap_cmd_q;
    cap_key_d   = cap_key_q;
    upd_vld_d   = 1'b0;
    upd_prod_d  = upd_prod_q;
    upd_cmd_d   = upd_cmd_q;
    upd_key_d   = upd_key_q;
    upd_size_d  = upd_size_q;
    lut_vld_d   = 1'b0;
    lut_prod_d  = lut_prod_q;
    lut_level_d = lut_level_q;
    err_inc     = 1'b0;
    if (accept) begin
      if (i_msg_sop) begin
        // A sop mid-update aborts it; err_inc is a flag so an abort plus an illegal opcode counts once.
        if (state_q == ST_BODY) err_inc = 1'b1;
        if (is_upd_op(op)) begin
          cap_prod_d = i_msg_data[23:16];
          cap_cmd_d  = op_to_cmd(op);
          cap_key_d  = i_msg_data[15:0];
          state_d    = ST_BODY;
        end else if (op == OP_QUERY) begin
          lut_vld_d   = 1'b1;
          lut_prod_d  = i_msg_data[23:16];
          lut_level_d = i_msg_data[3:0];
          state_d     = ST_IDLE;
        end else begin
          err_inc = 1'b1;
          state_d = ST_DROP;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            err_inc = 1'b1;
            state_d = ST_DROP;
          end
          ST_BODY: begin
            upd_vld_d  = 1'b1;
            upd_prod_d = cap_prod_q;
            upd_cmd_d  = cap_cmd_q;
            upd_key_d  = cap_key_q;
            upd_size_d = i_msg_data[15:0];
            state_d    = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
    err_d = (err_inc && (err_q != '1)) ? err_q + ERR_CNT_W'(1) : err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rdy_pre_q   <= 1'b0;
      rdy_q       <= 1'b0;
      cap_prod_q  <= '0;
      cap_cmd_q   <= CMD_ADD;
      cap_key_q   <= '0;
      upd_vld_q   <= 1'b0;
      upd_prod_q  <= '0;
      upd_cmd_q   <= CMD_ADD;
      upd_key_q   <= '0;
      upd_size_q  <= '0;
      lut_vld_q   <= 1'b0;
      lut_prod_q  <= '0;
      lut_level_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      rdy_pre_q   <= 1'b1;
      rdy_q       <= rdy_pre_q;
      cap_prod_q  <= cap_prod_d;
      cap_cmd_q   <= cap_cmd_d;
      cap_key_q   <= cap_key_d;
      upd_vld_q   <= upd_vld_d;
      upd_prod_q  <= upd_prod_d;
      upd_cmd_q   <= upd_cmd_d;
      upd_key_q   <= upd_key_d;
      upd_size_q  <= upd_size_d;
      lut_vld_q   <= lut_vld_d;
      lut_prod_q  <= lut_prod_d;
      lut_level_q <= lut_level_d;
      err_q       <= err_d;
    end
  end

  assign o_msg_rdy     = rdy_q;
  assign o_upd_vld     = upd_vld_q;
  assign o_upd_prod_id = upd_prod_q;
  assign o_upd_cmd     = upd_cmd_q;
  assign o_upd_key     = upd_key_q;
  assign o_upd_size    = upd_size_q;
  assign o_lut_vld     = lut_vld_q;
  assign o_lut_prod_id = lut_prod_q;
  assign o_lut_level   = lut_level_q;
  assign o_err_cnt     = err_q;

endmodule

// File: tb/tb_v_msg_dec.sv
// Scoreboard bench for v_msg_dec; a second instance with a 2-bit counter exercises saturation.
module tb_v_msg_dec;
  import v_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic msg_vld = 1'b0;
  logic msg_sop = 1'b0;
  logic [31:0] msg_data = '0;

  logic msg_rdy, upd_vld, lut_vld;
  id_t upd_prod, lut_prod;
  cmd_t upd_cmd;
  key_t upd_key;
  size_t upd_size;
  level_t lut_level;
  logic [15:0] err_cnt;

  logic s_rdy, s_upd_vld, s_lut_vld;
  id_t s_upd_prod, s_lut_prod;
  cmd_t s_upd_cmd;
  key_t s_upd_key;
  size_t s_upd_size;
  level_t s_lut_level;
  logic [1:0] s_err;

  v_msg_dec #(.ERR_CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .i_msg_vld(msg_vld), .i_msg_sop(msg_sop), .i_msg_data(msg_data),
    .o_msg_rdy(msg_rdy), .o_upd_vld(upd_vld), .o_upd_prod_id(upd_prod), .o_upd_cmd(upd_cmd),
    .o_upd_key(upd_key), .o_upd_size(upd_size), .o_lut_vld(lut_vld), .o_lut_prod_id(lut_prod),
    .o_lut_level(lut_level), .o_err_cnt(err_cnt)
  );

  v_msg_dec #(.ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .i_msg_vld(msg_vld), .i_msg_sop(msg_sop), .i_msg_data(msg_data),
    .o_msg_rdy(s_rdy), .o_upd_vld(s_upd_vld), .o_upd_prod_id(s_upd_prod), .o_upd_cmd(s_upd_cmd),
    .o_upd_key(s_upd_key), .o_upd_size(s_upd_size), .o_lut_vld(s_lut_vld), .o_lut_prod_id(s_lut_prod),
    .o_lut_level(s_lut_level), .o_err_cnt(s_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_upd;
    logic [7:0]  prod;
    logic [1:0]  cmd;
    logic [15:0] key;
    logic [15:0] size;
    logic [3:0]  level;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_upd(input logic [7:0] p, input cmd_t c, input logic [15:0] k, input logic [15:0] s);
    exp_t x;
    x = '0;
    x.is_upd = 1'b1; x.prod = p; x.cmd = c; x.key = k; x.size = s;
    sb.push_back(x);
  endtask

  task automatic push_lut(input logic [7:0] p, input logic [3:0] l);
    exp_t x;
    x = '0;
    x.prod = p; x.level = l;
    sb.push_back(x);
  endtask

  task automatic send(input logic sop, input logic [31:0] d);
    int n;
    @(negedge clk);
    msg_vld = 1'b1; msg_sop = sop; msg_data = d;
    n = 0;
    while (!msg_rdy && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!msg_rdy) chk("rdy_timeout", 32'(msg_rdy), 1);
    @(posedge clk);
  endtask

  task automatic stop_drv();
    @(negedge clk);
    msg_vld = 1'b0; msg_sop = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (upd_vld && lut_vld) chk("both_vld", 32'(upd_vld & lut_vld), 0);
      if (upd_vld || lut_vld) begin
        if (sb.size() == 0) begin
          chk("unexp_pulse", {30'd0, upd_vld, lut_vld}, 0);
        end else begin
          e = sb.pop_front();
          chk("kind", 32'(upd_vld), 32'(e.is_upd));
          if (e.is_upd) begin
            chk("upd_no_x", 32'($isunknown({upd_prod, upd_cmd, upd_key, upd_size})), 0);
            chk("upd_prod", 32'(upd_prod), 32'(e.prod));
            chk("upd_cmd", 32'(upd_cmd), 32'(e.cmd));
            chk("upd_key", 32'(upd_key), 32'(e.key));
            chk("upd_size", 32'(upd_size), 32'(e.size));
          end else begin
            chk("lut_no_x", 32'($isunknown({lut_prod, lut_level})), 0);
            chk("lut_prod", 32'(lut_prod), 32'(e.prod));
            chk("lut_level", 32'(lut_level), 32'(e.level));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 32'(msg_rdy), 0);
    chk("rst_upd_vld", 32'(upd_vld), 0);
    chk("rst_lut_vld", 32'(lut_vld), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_fields", {upd_prod, upd_key, 8'(upd_cmd)}, 0);
    chk("rst_fields2", {upd_size, lut_prod, 4'd0, lut_level}, 0);
    rst = 1'b1;
    @(posedge clk); #1 chk("rdy_first", 32'(msg_rdy), 0);
    @(posedge clk); #1 chk("rdy_second", 32'(msg_rdy), 1);

    // ADD
    push_upd(8'd7, CMD_ADD, 16'h1234, 16'h00FF);
    send(1'b1, 32'h0107_1234);
    send(1'b0, 32'h0000_00FF);
    stop_drv();
    chk("add_lat", 32'(upd_vld), 1);
    chk("add_nolut", 32'(lut_vld), 0);

    // QUERY
    push_lut(8'd3, 4'd5);
    send(1'b1, 32'h1003_0005);
    stop_drv();
    chk("qry_lat", 32'(lut_vld), 1);
    chk("qry_noupd", 32'(upd_vld), 0);

    // abort pending DEL with a fresh query
    push_lut(8'd2, 4'd1);
    send(1'b1, 32'h0201_AAAA);
    send(1'b1, 32'h1002_0001);
    stop_drv();
    chk("abort_lut", 32'(lut_vld), 1);
    chk("abort_err", 32'(err_cnt), 1);
    chk("abort_sat", 32'(s_err), 1);

    // illegal opcode, trailing beats dropped, then a clean ADD
    send(1'b1, 32'h7F00_0000);
    send(1'b0, 32'h0107_1234);
    send(1'b0, 32'h0000_00FF);
    push_upd(8'd5, CMD_ADD, 16'h0042, 16'h0010);
    send(1'b1, 32'h0105_0042);
    send(1'b0, 32'h0000_0010);
    stop_drv();
    chk("illegal_err", 32'(err_cnt), 2);
    chk("illegal_sat", 32'(s_err), 2);

    // DEL with an idle gap, then REPLACE
    push_upd(8'd9, CMD_DEL, 16'h1111, 16'h5678);
    send(1'b1, 32'h0209_1111);
    stop_drv();
    repeat (3) @(posedge clk);
    send(1'b0, 32'hABCD_5678);
    push_upd(8'hAA, CMD_REPLACE, 16'h0001, 16'h0002);
    send(1'b1, 32'h03AA_0001);
    send(1'b0, 32'h0000_0002);
    stop_drv();
    repeat (2) @(posedge clk);
    chk("gap_err", 32'(err_cnt), 2);

    // non-sop beats in IDLE count once
    send(1'b0, 32'h1001_0002);
    send(1'b0, 32'h1234_5678);
    stop_drv();
    chk("nosop_err", 32'(err_cnt), 3);
    chk("nosop_sat", 32'(s_err), 3);
    push_lut(8'd1, 4'd2);
    send(1'b1, 32'h1001_0002);
    stop_drv();

    // saturation, and abort with illegal opcode counting once
    for (int i = 0; i < 5; i++) send(1'b1, 32'hFF00_0000 | 32'(i));
    stop_drv();
    chk("sat_main", 32'(err_cnt), 8);
    chk("sat_2bit", 32'(s_err), 3);
    send(1'b1, 32'h0100_0000);
    send(1'b1, 32'hEE00_0000);
    stop_drv();
    chk("abort_illegal_once", 32'(err_cnt), 9);
    repeat (2) @(posedge clk);
    chk("hold_upd", {upd_prod, 6'd0, 2'(upd_cmd), upd_key}, {8'hAA, 6'd0, 2'(CMD_REPLACE), 16'h0001});
    chk("hold_size", 32'(upd_size), 2);
    chk("hold_lut", {lut_prod, lut_level}, {8'd1, 4'd2});

    // reset in the middle of an ADD
    send(1'b1, 32'h0107_0001);
    @(negedge clk);
    msg_vld = 1'b0; msg_sop = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_rdy", 32'(msg_rdy), 0);
    chk("midrst_err", 32'(err_cnt), 0);
    chk("midrst_fields", {upd_prod, upd_key}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 chk("midrst_rdy_first", 32'(msg_rdy), 0);
    @(posedge clk); #1 chk("midrst_rdy_second", 32'(msg_rdy), 1);
    send(1'b0, 32'h0000_00FF);
    stop_drv();
    chk("midrst_no_upd", 32'(upd_vld), 0);
    chk("midrst_discard_err", 32'(err_cnt), 1);

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/v_msg_dec.md
V_MSG_DEC -- requirements
Module: v_msg_dec

Interface
REQ-001 Parameter ERR_CNT_W, default 16, width of the saturating error counter.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-low (asserted at 0).
REQ-004 i_msg_vld  in  1  input beat valid.
REQ-005 i_msg_sop  in  1  beat is first beat of a message.
REQ-006 i_msg_data  in  32  beat payload.
REQ-007 o_msg_rdy  out  1  beat accepted when i_msg_vld & o_msg_rdy.
REQ-008 o_upd_vld  out  1  list update valid, single-cycle pulse, no backpressure.
REQ-009 o_upd_prod_id / o_upd_cmd / o_upd_key / o_upd_size  out  v_pkg::id_t / cmd_t / key_t / size_t  update fields.
REQ-010 o_lut_vld  out  1  list query valid, single-cycle pulse.
REQ-011 o_lut_prod_id / o_lut_level  out  v_pkg::id_t / level_t  query fields.
REQ-012 o_err_cnt  out  ERR_CNT_W  count of dropped messages, saturating.

Function
REQ-013 Message format, beat0: [31:24] opcode, [23:16] prod_id, [15:0] key (update) or [3:0] level (query).
REQ-014 Update beat1: [15:0] size; [31:16] ignored.
REQ-015 Opcodes: 0x01 ADD, 0x02 DEL, 0x03 REPLACE (two beats each); 0x10 QUERY (one beat); all others illegal.
REQ-016 FSM states IDLE, BODY, DROP; reset state IDLE.
REQ-017 IDLE: accepted beat with sop and update opcode -> capture prod_id/cmd/key, go BODY.
REQ-018 IDLE: accepted beat with sop and QUERY -> o_lut_vld high next cycle with prod_id and level, stay IDLE.
REQ-019 IDLE: sop with illegal opcode -> increment o_err_cnt, go DROP.
REQ-020 IDLE: accepted beat without sop -> increment o_err_cnt once, go DROP.
REQ-021 BODY: accepted beat without sop -> o_upd_vld high next cycle with captured fields and size, go IDLE.
REQ-022 BODY: accepted beat with sop -> abort pending update (no o_upd_vld), increment o_err_cnt, decode the beat as a fresh beat0 per REQ-017..019.
REQ-023 DROP: discard non-sop beats silently; sop beat decoded as in IDLE.
REQ-024 Latency: output valid exactly one cycle after the accepting edge of the final beat; outputs registered.
REQ-025 o_upd_vld and o_lut_vld are never high in the same cycle.
REQ-026 Output field registers hold last value when valid is low.
REQ-027 o_msg_rdy is 0 during reset and the first cycle after reset release, 1 thereafter.
REQ-028 Beats with i_msg_vld=0 change no state; idle gaps mid-message are legal.
REQ-029 Increment and abort in the same cycle count once; o_err_cnt holds at all-ones.

Reset
REQ-030 On rst=0: state IDLE, o_upd_vld=0, o_lut_vld=0, o_msg_rdy=0, o_err_cnt=0, all field outputs 0.
REQ-031 Reset mid-message discards partial message; no valid pulse after release.

Structure
REQ-032 v_pkg holds id_t(8b), key_t(16b), size_t(16b), level_t(4b), cmd_t enum (ADD=0, DEL=1, REPLACE=2), opcode constants, and the FSM state enum.
REQ-033 Single flat module; no sub-modules.
REQ-034 Bench binds existing not-X checks on update/query buses to this block's outputs.

Verification
REQ-035 ADD: beats {sop,0x01_07_1234},{0x0000_00FF} -> next cycle o_upd_vld=1, prod_id=7, cmd=ADD, key=0x1234, size=0xFF.
REQ-036 QUERY: beat {sop,0x10_03_0005} -> next cycle o_lut_vld=1, prod_id=3, level=5; o_upd_vld=0.
REQ-037 Abort: {sop,0x02_01_AAAA} then {sop,0x10_02_0001} -> no update, o_err_cnt=1, query prod_id=2 level=1 emitted.
REQ-038 Illegal: {sop,0x7F_..},2 non-sop beats, then valid ADD -> o_err_cnt=1, only the ADD update emitted.
REQ-039 Saturation: ERR_CNT_W=2, five illegal messages -> o_err_cnt=3.
REQ-040 Reset after beat0 of ADD, then release -> no o_upd_vld; o_msg_rdy returns to 1 on second cycle.
